// File: rtl/adain_stream_engine.sv
// adain_stream_engine: streaming AdaIN normaliser (buffer+stats, sqrt, divide, affine replay)
module adain_stream_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC = 8,
  parameter int LOG2_N_MAX = 7,
  parameter int EPS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(LOG2_N_MAX+1)-1:0]   log2_n,
  input  logic [DATA_W-1:0]                 ys,
  input  logic [DATA_W-1:0]                 yb,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_W-1:0]                 s_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_W-1:0]                 m_data,
  output logic                              m_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);
  localparam int LW = $clog2(LOG2_N_MAX+1);
  localparam int N_MAX = 1 << LOG2_N_MAX;
  localparam int SW = DATA_W + LOG2_N_MAX;
  localparam int QW = 2*DATA_W + LOG2_N_MAX;
  localparam int VW = 2*DATA_W;
  localparam int DW = DATA_W + FRAC;
  localparam int KW = DW + 1;
  localparam int PW = DATA_W + 1 + KW;
  localparam int CW = LOG2_N_MAX + 1;
  localparam int IW = $clog2(DW+1);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_STAT = 3'd2;
  localparam logic [2:0] S_SQRT = 3'd3;
  localparam logic [2:0] S_DIV  = 3'd4;
  localparam logic [2:0] S_EMIT = 3'd5;
  localparam logic signed [PW:0] YMAX = $signed({{(PW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PW:0] YMIN = $signed({{(PW+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}});

  logic [2:0]                state;
  logic [LW-1:0]             ln;
  logic [DATA_W-1:0]         ys_r, yb_r, ys_abs;
  logic [DATA_W-1:0]         mem [N_MAX];
  logic [CW-1:0]             cnt, n_len;
  logic signed [SW-1:0]      sum;
  logic [QW-1:0]             sumsq, ex2;
  logic signed [DATA_W-1:0]  mean, mean_n;
  logic signed [VW-1:0]      xs, sq, me, mm;
  logic [QW+1:0]             vd, vp;
  logic [VW-1:0]             rad, var_sat;
  logic [DATA_W+1:0]         rem, rem_n;
  logic [DATA_W+3:0]         rem_t, trial;
  logic [DATA_W-1:0]         root, root_n, sigma;
  logic                      ge, dge;
  logic [DATA_W-1:0]         drem, drem_n;
  logic [DATA_W:0]           drt;
  logic [DW-1:0]             qd, qd_n;
  logic signed [KW-1:0]      q, scale, scale_n;
  logic [IW-1:0]             it;
  logic                      hs_in, adv, issue;
  logic                      v1, l1, v2, l2;
  logic [DATA_W-1:0]         x1;
  logic signed [DATA_W:0]    d;
  logic signed [PW-1:0]      de, se, p_n, p2;
  logic signed [PW:0]        pe, yw;
  logic [DATA_W-1:0]         y_sat;

  assign s_ready = state == S_LOAD;
  assign busy    = state != S_IDLE;

  // datapath arithmetic: accumulate terms, statistics, sqrt/divide steps, affine output
  always_comb begin
    n_len   = CW'(1) << ln;
    hs_in   = s_valid & s_ready;
    adv     = m_ready | ~m_valid;
    issue   = state == S_EMIT && cnt != n_len && adv;
    xs      = {{(VW-DATA_W){s_data[DATA_W-1]}}, s_data};
    sq      = xs * xs;
    mean_n  = DATA_W'(sum >>> ln);
    ex2     = sumsq >> ln;
    me      = {{(VW-DATA_W){mean_n[DATA_W-1]}}, mean_n};
    mm      = me * me;
    vd      = {2'b00, ex2} - {{(QW+2-VW){1'b0}}, mm};
    vp      = vd[QW+1] ? (QW+2)'(EPS) : vd + (QW+2)'(EPS);
    var_sat = |vp[QW+1:VW] ? '1 : vp[VW-1:0];
    rem_t   = {rem, rad[VW-1 -: 2]};
    trial   = {2'b00, root, 2'b01};
    ge      = rem_t >= trial;
    rem_n   = (DATA_W+2)'(ge ? rem_t - trial : rem_t);
    root_n  = {root[DATA_W-2:0], ge};
    ys_abs  = ys_r[DATA_W-1] ? -ys_r : ys_r;
    drt     = {drem, qd[DW-1]};
    dge     = drt >= {1'b0, sigma};
    drem_n  = DATA_W'(dge ? drt - {1'b0, sigma} : drt);
    qd_n    = {qd[DW-2:0], dge};
    q       = {1'b0, qd_n};
    scale_n = ys_r[DATA_W-1] ? -q : q;
    d       = {x1[DATA_W-1], x1} - {mean[DATA_W-1], mean};
    de      = {{(PW-DATA_W-1){d[DATA_W]}}, d};
    se      = {{(PW-KW){scale[KW-1]}}, scale};
    p_n     = de * se;
    pe      = {p2[PW-1], p2};
    yw      = (pe >>> FRAC) + $signed({{(PW+1-DATA_W){yb_r[DATA_W-1]}}, yb_r});
    y_sat   = yw > YMAX ? {1'b0, {(DATA_W-1){1'b1}}} :
              yw < YMIN ? {1'b1, {(DATA_W-1){1'b0}}} : yw[DATA_W-1:0];
  end

  // frame buffer write port, filled during LOAD
  always_ff @(posedge clk) begin
    if (hs_in) mem[cnt[LOG2_N_MAX-1:0]] <= s_data;
  end

  // control FSM, iterative sqrt/divide and the three-stage emit pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ln <= '0;
      ys_r <= '0;
      yb_r <= '0;
      cnt <= '0;
      sum <= '0;
      sumsq <= '0;
      mean <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      sigma <= '0;
      drem <= '0;
      qd <= '0;
      scale <= '0;
      it <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      x1 <= '0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      p2 <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (32'(log2_n) > LOG2_N_MAX) err <= 1'b1;
          else begin
            ln <= log2_n;
            ys_r <= ys;
            yb_r <= yb;
            sum <= '0;
            sumsq <= '0;
            cnt <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: if (hs_in) begin
          sum <= sum + {{(SW-DATA_W){s_data[DATA_W-1]}}, s_data};
          sumsq <= sumsq + {{(QW-VW){1'b0}}, sq};
          cnt <= cnt + CW'(1);
          if (cnt == n_len - CW'(1)) state <= S_STAT;
        end
        S_STAT: begin
          mean <= mean_n;
          rad <= var_sat;
          rem <= '0;
          root <= '0;
          it <= '0;
          state <= S_SQRT;
        end
        S_SQRT: begin
          rad <= rad << 2;
          rem <= rem_n;
          root <= root_n;
          it <= it + IW'(1);
          if (it == IW'(DATA_W-1)) begin
            sigma <= root_n;
            drem <= '0;
            qd <= {ys_abs, {FRAC{1'b0}}};
            it <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          drem <= drem_n;
          qd <= qd_n;
          it <= it + IW'(1);
          if (it == IW'(DW-1)) begin
            scale <= scale_n;
            cnt <= '0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (issue) cnt <= cnt + CW'(1);
          if (m_valid && m_ready && m_last) begin
            done <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        v1 <= issue;
        l1 <= cnt == n_len - CW'(1);
        x1 <= mem[cnt[LOG2_N_MAX-1:0]];
        v2 <= v1;
        l2 <= l1;
        p2 <= p_n;
        m_valid <= v2;
        m_last <= v2 & l2;
        m_data <= y_sat;
      end
    end
  end
endmodule

// File: tb/tb_adain_stream_engine.sv
// tb_adain_stream_engine: scoreboard bench for the streaming AdaIN engine
module tb_adain_stream_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] log2_n = '0;
  logic [15:0] ys = '0;
  logic [15:0] yb = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] s_data = '0;
  logic m_valid;
  logic m_ready = 1'b1;
  logic [15:0] m_data;
  logic m_last;
  logic busy;
  logic done;
  logic err;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int bp_mode = 0;
  logic [16:0] exp_q[$];
  logic [15:0] smp [16];

  adain_stream_engine #(.DATA_W(16), .FRAC(8), .LOG2_N_MAX(6), .EPS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .log2_n(log2_n), .ys(ys), .yb(yb),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_model(int lg, logic [15:0] ysv, logic [15:0] ybv);
    longint sum = 0, sq = 0, m, v, sg = 0, t, sc, y, x, ya;
    longint lim = 32'hFFFF_FFFF;
    logic [15:0] m16;
    for (int i = 0; i < (1 << lg); i++) begin
      x = longint'($signed(smp[i]));
      sum += x;
      sq += x * x;
    end
    m16 = 16'(sum >>> lg);
    m = longint'($signed(m16));
    v = (sq >>> lg) - m * m;
    if (v < 0) v = 0;
    v += 1;
    if (v > lim) v = lim;
    for (int b = 15; b >= 0; b--) begin
      t = sg | (longint'(1) << b);
      if (t * t <= v) sg = t;
    end
    ya = longint'($signed(ysv));
    if (ya < 0) ya = -ya;
    sc = (ya * 256) / sg;
    if (ysv[15]) sc = -sc;
    for (int i = 0; i < (1 << lg); i++) begin
      x = longint'($signed(smp[i]));
      y = (((x - m) * sc) >>> 8) + longint'($signed(ybv));
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      exp_q.push_back({1'(i == (1 << lg) - 1), 16'(y)});
    end
  endfunction

  task automatic load_basic(input bit push);
    smp[0] = 16'h0100; smp[1] = 16'h0200; smp[2] = 16'h0300; smp[3] = 16'h0400;
    if (push) begin
      exp_q.push_back({1'b0, 16'hFEA8});
      exp_q.push_back({1'b0, 16'hFF8D});
      exp_q.push_back({1'b0, 16'h0072});
      exp_q.push_back({1'b1, 16'h0157});
    end
  endtask

  task automatic run_frame(input int lg, input logic [15:0] ysv, input logic [15:0] ybv,
                           input bit inject, input bit abort);
    int b;
    log2_n = 3'(lg);
    ys = ysv;
    yb = ybv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_acc", {busy, s_ready}, 2'b11);
    for (int i = 0; i < (1 << lg); i++) begin
      s_data = smp[i];
      s_valid = 1'b1;
      b = 0;
      while (!s_ready && b < 100) begin @(posedge clk); #1; b++; end
      if (b == 100) chk("s_ready_wait", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (inject) begin
      repeat (25) @(posedge clk);
      #1;
      log2_n = 3'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("ignore_err", err, 0);
      chk("ignore_busy", busy, 1);
    end
    if (abort) begin
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_outs", {s_ready, m_valid, m_last, busy, done, err, m_data}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      b = 0;
      while (!done && b < 2000) begin @(posedge clk); #1; b++; end
      chk("done_seen", done, 1);
    end
  endtask

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      m_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? ph == 0 : 1'($urandom_range(0, 1));
      ph = (ph + 1) % 3;
    end
  end

  initial begin
    logic prev_stall = 1'b0;
    logic prev_lh = 1'b0;
    logic prev_mv = 1'b0;
    logic [17:0] prev_out = '0;
    logic [16:0] e;
    int hs_cyc = 0;
    bit armed = 0;
    forever begin
      @(negedge clk);
      if (done || prev_lh) chk("done_pulse", done, prev_lh);
      if (done) chk("idle_on_done", busy, 0);
      if (prev_stall) chk("hold", {m_valid, m_last, m_data}, prev_out);
      if (s_valid && s_ready) begin hs_cyc = cyc; armed = 1; end
      if (m_valid && !prev_mv && armed) begin chk("latency", cyc - hs_cyc, 45); armed = 0; end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", m_data, 'x);
        else begin
          e = exp_q.pop_front();
          chk("data", m_data, e[15:0]);
          chk("last", m_last, e[16]);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out = {m_valid, m_last, m_data};
      prev_lh = m_valid && m_ready && m_last;
      prev_mv = m_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_outs", {s_ready, m_valid, m_last, busy, done, err, m_data}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    log2_n = 3'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_idle", {busy, s_ready}, 0);
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    load_basic(1);
    run_frame(2, 16'h0100, 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      smp[i] = 16'h0200;
      exp_q.push_back({1'(i == 7), 16'h0080});
    end
    run_frame(3, 16'h0200, 16'h0080, 0, 0);
    smp[0] = 16'hFF00; smp[1] = 16'h0100;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'h7FFF});
    run_frame(1, 16'h7F00, 16'h7F00, 0, 0);
    bp_mode = 1;
    load_basic(1);
    run_frame(2, 16'h0100, 16'h0000, 0, 0);
    bp_mode = 0;
    load_basic(1);
    run_frame(2, 16'h0100, 16'h0000, 1, 0);
    load_basic(0);
    run_frame(2, 16'h0100, 16'h0000, 0, 1);
    load_basic(1);
    run_frame(2, 16'h0100, 16'h0000, 0, 0);
    bp_mode = 2;
    for (int r = 0; r < 3; r++) begin
      int lg;
      logic [15:0] ysv, ybv;
      lg = r == 0 ? 4 : r == 1 ? 0 : 3;
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom_range(0, 4095)) - 16'h0800;
      ysv = 16'($urandom_range(0, 1023)) - 16'h0200;
      ybv = 16'($urandom_range(0, 511)) - 16'h0100;
      push_model(lg, ysv, ybv);
      run_frame(lg, ysv, ybv, 0, 0);
    end
    bp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
